// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/done handshake and shift-add multiply.
// Define ALU_MC_DIV_EN to add the unsigned restoring divider (opcode 0x0A).
module alu_mc #(
   parameter int WIDTH  = 32,
   parameter int OPRN_W = 6
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [OPRN_W-1:0] oprn,
   input  logic [WIDTH-1:0]  op1,
   input  logic [WIDTH-1:0]  op2,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              err
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [OPRN_W-1:0] OP_ADD = OPRN_W'(1);
   localparam logic [OPRN_W-1:0] OP_SUB = OPRN_W'(2);
   localparam logic [OPRN_W-1:0] OP_MUL = OPRN_W'(3);
   localparam logic [OPRN_W-1:0] OP_SRL = OPRN_W'(4);
   localparam logic [OPRN_W-1:0] OP_SLL = OPRN_W'(5);
   localparam logic [OPRN_W-1:0] OP_AND = OPRN_W'(6);
   localparam logic [OPRN_W-1:0] OP_OR  = OPRN_W'(7);
   localparam logic [OPRN_W-1:0] OP_NOR = OPRN_W'(8);
   localparam logic [OPRN_W-1:0] OP_SLT = OPRN_W'(9);
`ifdef ALU_MC_DIV_EN
   localparam logic [OPRN_W-1:0] OP_DIV = OPRN_W'(10);
`endif

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef ALU_MC_DIV_EN
   typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, EXEC, MUL, DONE} state_t;
`endif

   state_t state, state_n, route;

   logic              accept;
   logic              iter;
   logic              it_last;
   logic [OPRN_W-1:0] opr_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [CW-1:0]     cnt;

   logic [WIDTH-1:0]  acc, mcand, mplier, acc_n;

`ifdef ALU_MC_DIV_EN
   logic [WIDTH-1:0]  rem, quo, dvs;
   logic [WIDTH-1:0]  rem_n, quo_n;
   logic [WIDTH:0]    rem_sh, diff;
   logic              qbit;
`endif

   logic [WIDTH-1:0]  ex_res, res_n;
   logic              ex_err, err_n, ld_res;

   // Handshake status is a pure function of the FSM state
   always_comb begin
      busy = (state != IDLE) && (state != DONE);
      done = (state == DONE);
   end

   // A new op is taken whenever the unit is not busy, including in DONE
   always_comb begin
      accept  = start && (state == IDLE || state == DONE);
      it_last = (cnt == LAST);
      iter    = (state == MUL);
`ifdef ALU_MC_DIV_EN
      if (state == DIV) iter = 1'b1;
`endif
   end

   // Pick the working state for the op presented with start
   always_comb begin
      route = EXEC;
      if (oprn == OP_MUL) begin
         route = MUL;
      end
`ifdef ALU_MC_DIV_EN
      else if (oprn == OP_DIV && op2 != '0) begin
         route = DIV;
      end
`endif
   end

   // Single-cycle datapath on the latched operands
   always_comb begin
      ex_res = '0;
      ex_err = 1'b0;
      unique case (opr_q)
         OP_ADD: ex_res = a_q + b_q;
         OP_SUB: ex_res = a_q - b_q;
         OP_SRL: ex_res = a_q >> b_q;
         OP_SLL: ex_res = a_q << b_q;
         OP_AND: ex_res = a_q & b_q;
         OP_OR:  ex_res = a_q | b_q;
         OP_NOR: ex_res = ~(a_q | b_q);
         OP_SLT: ex_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
`ifdef ALU_MC_DIV_EN
         // Only a zero divisor reaches EXEC with a divide
         OP_DIV: begin
            ex_res = '1;
            ex_err = 1'b1;
         end
`endif
         default: ex_err = 1'b1;
      endcase
   end

   // One multiplier bit per step, LSB first
   always_comb begin
      acc_n = acc + (mplier[0] ? mcand : '0);
   end

`ifdef ALU_MC_DIV_EN
   // One restoring-divide step, quotient bit MSB first
   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs};
      qbit   = ~diff[WIDTH];
      rem_n  = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_n  = {quo[WIDTH-2:0], qbit};
   end
`endif

   // Next state and result-load selection
   always_comb begin
      state_n = state;
      ld_res  = 1'b0;
      res_n   = ex_res;
      err_n   = ex_err;
      unique case (state)
         IDLE, DONE: state_n = start ? route : IDLE;
         EXEC: begin
            state_n = DONE;
            ld_res  = 1'b1;
         end
         MUL: begin
            if (it_last) begin
               state_n = DONE;
               ld_res  = 1'b1;
               res_n   = acc_n;
               err_n   = 1'b0;
            end
         end
`ifdef ALU_MC_DIV_EN
         DIV: begin
            if (it_last) begin
               state_n = DONE;
               ld_res  = 1'b1;
               res_n   = quo_n;
               err_n   = 1'b0;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end

   // Operand latch and iteration counter
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         opr_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cnt   <= '0;
      end else if (accept) begin
         opr_q <= oprn;
         a_q   <= op1;
         b_q   <= op2;
         cnt   <= '0;
      end else if (iter) begin
         cnt   <= cnt + CW'(1);
      end
   end

   // Shift-add multiplier registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= op1;
         mplier <= op2;
      end else if (state == MUL) begin
         acc    <= acc_n;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

`ifdef ALU_MC_DIV_EN
   // Restoring divider registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
      end else if (accept) begin
         rem <= '0;
         quo <= op1;
         dvs <= op2;
      end else if (state == DIV) begin
         rem <= rem_n;
         quo <= quo_n;
      end
   end
`endif

   // Result and flags change only on entry to DONE
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         result <= '0;
         zero   <= 1'b0;
         err    <= 1'b0;
      end else if (ld_res) begin
         result <= res_n;
         zero   <= (res_n == '0);
         err    <= err_n;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=32.
// Expected results and done cycles are queued at issue time.
module tb_alu_mc;

   logic        CLK;
   logic        RST;
   logic        start;
   logic [5:0]  oprn;
   logic [31:0] op1, op2;
   logic        busy, done, zero, err;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        z;
      logic        e;
      int          at;
   } exp_t;

   exp_t sb[$];
   exp_t ex;

   alu_mc #(.WIDTH(32), .OPRN_W(6)) dut (
      .CLK(CLK), .RST(RST), .start(start),
      .oprn(oprn), .op1(op1), .op2(op2),
      .busy(busy), .done(done), .result(result),
      .zero(zero), .err(err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   // Monitor: every done must match the oldest queued expectation
   always @(negedge CLK) begin
      if (!RST && done) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL stray_done: res=%h at cyc %0d, none expected",
                     result, cyc);
         end else begin
            ex = sb.pop_front();
            if (result !== ex.res || zero !== ex.z || err !== ex.e ||
                busy !== 1'b0 || cyc != ex.at) begin
               bad++;
               $display("FAIL %s: got res=%h z=%b e=%b busy=%b cyc=%0d, want res=%h z=%b e=%b busy=0 cyc=%0d",
                        ex.name, result, zero, err, busy, cyc,
                        ex.res, ex.z, ex.e, ex.at);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // Present one op for one cycle; called at posedge+1
   task automatic issue(input string nm, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic z,
                        input logic e, input int lat, input bit keep);
      exp_t x;
      start = 1'b1;
      oprn  = op;
      op1   = a;
      op2   = b;
      if (keep) begin
         x.name = nm; x.res = r; x.z = z; x.e = e; x.at = cyc + lat;
         sb.push_back(x);
      end
      @(posedge CLK); #1;
      start = 1'b0;
      oprn  = 6'($urandom);
      op1   = $urandom;
      op2   = $urandom;
   endtask

   // Returns in the done cycle, at posedge+1
   task automatic wait_done(input string nm);
      for (int i = 0; i < 200; i++) begin
         if (done) return;
         @(posedge CLK); #1;
      end
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for done", nm);
   endtask

   task automatic run(input string nm, input logic [5:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z,
                      input logic e, input int lat);
      issue(nm, op, a, b, r, z, e, lat, 1'b1);
      wait_done(nm);
      @(posedge CLK); #1;
   endtask

   initial begin
      RST = 1'b1; start = 1'b0; oprn = '0; op1 = '0; op2 = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      run("add_1_1", 6'h01, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 2);

      // Reset during a multiply aborts it with no done
      issue("mul_abort", 6'h03, 32'h1234, 32'h10, '0, 1'b0, 1'b0, 0, 1'b0);
      repeat (4) begin
         @(posedge CLK); #1;
      end
      RST = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (40) begin
         @(posedge CLK); #1;
      end
      run("add_2_3", 6'h01, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 2);

      run("add_wrap", 6'h01, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 2);
      run("sub_5_7", 6'h02, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
      run("nor_0_0", 6'h08, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2);
      run("slt_3_max", 6'h09, 32'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 2);
      run("slt_max_3", 6'h09, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b1, 1'b0, 2);
      run("and", 6'h06, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000,
          1'b0, 1'b0, 2);
      run("or", 6'h07, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0,
          1'b0, 1'b0, 2);

      run("mul_hi_drop", 6'h03, 32'h0001_0000, 32'h0001_0001,
          32'h0001_0000, 1'b0, 1'b0, 33);
      run("mul_to_zero", 6'h03, 32'h0001_0000, 32'h0001_0000,
          32'h0000_0000, 1'b1, 1'b0, 33);
      run("mul_7_6", 6'h03, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33);

      run("srl_31", 6'h04, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 2);
      run("sll_32", 6'h05, 32'd1, 32'd32, 32'd0, 1'b1, 1'b0, 2);
      run("sll_4", 6'h05, 32'd3, 32'd4, 32'h30, 1'b0, 1'b0, 2);

      // Start while busy is dropped; only the multiply reports
      issue("mul_busy", 6'h03, 32'd9, 32'd5, 32'd45, 1'b0, 1'b0, 33, 1'b1);
      @(posedge CLK); #1;
      issue("ignored", 6'h01, 32'd1, 32'd1, '0, 1'b0, 1'b0, 0, 1'b0);
      wait_done("mul_busy");
      @(posedge CLK); #1;
      repeat (5) begin
         @(posedge CLK); #1;
      end

      // Start in the done cycle is accepted
      issue("b2b_a", 6'h01, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 2, 1'b1);
      wait_done("b2b_a");
      issue("b2b_b", 6'h02, 32'd50, 32'd8, 32'd42, 1'b0, 1'b0, 2, 1'b1);
      wait_done("b2b_b");
      @(posedge CLK); #1;

      run("illegal_0f", 6'h0F, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 2);
`ifdef ALU_MC_DIV_EN
      run("div_100_7", 6'h0A, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
      run("div_by_0", 6'h0A, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2);
`else
      run("div_off", 6'h0A, 32'd100, 32'd7, 32'd0, 1'b1, 1'b1, 2);
`endif
      run("err_clear", 6'h01, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0, 2);

      repeat (5) begin
         @(posedge CLK); #1;
      end
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
